// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: zeroes the register file after reset, then
// schedules even/odd pipe results into per-pipe delay lines and writes each one
// back exactly "lat" cycles after it was presented.
module rf_writeback_ctrl #(
    parameter int  REG_WIDTH  = 128,
    parameter int  REG_COUNT  = 128,
    parameter int  PIPE_DEPTH = 7,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid_even,
    input  logic                  res_valid_odd,
    input  logic [REG_WIDTH-1:0]  res_data_even,
    input  logic [REG_WIDTH-1:0]  res_data_odd,
    input  logic [ADDR_WIDTH-1:0] res_addr_even,
    input  logic [ADDR_WIDTH-1:0] res_addr_odd,
    input  logic [2:0]            res_lat_even,
    input  logic [2:0]            res_lat_odd,
    output logic [REG_WIDTH-1:0]  rt_wt_even,
    output logic [REG_WIDTH-1:0]  rt_wt_odd,
    output logic [ADDR_WIDTH-1:0] addr_rt_wt_even,
    output logic [ADDR_WIDTH-1:0] addr_rt_wt_odd,
    output logic                  wr_en_even,
    output logic                  wr_en_odd,
    output logic                  init_done,
    output logic                  wb_err
);

    localparam int HALF = REG_COUNT / 2;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_next;
    logic                  r_done, w_done_next;
    logic                  r_err, w_err_next;

    // Index 0 = even pipe, 1 = odd pipe. Slot 0 of each line is the head that
    // drives the write port; an entry with latency d is inserted at slot d-1.
    logic [1:0][PIPE_DEPTH-1:0]                 r_v, w_v_next;
    logic [1:0][PIPE_DEPTH-1:0][ADDR_WIDTH-1:0] r_a, w_a_next;
    logic [1:0][PIPE_DEPTH-1:0][REG_WIDTH-1:0]  r_d, w_d_next;

    logic [1:0]                 w_in_valid;
    logic [1:0][ADDR_WIDTH-1:0] w_in_addr;
    logic [1:0][REG_WIDTH-1:0]  w_in_data;
    logic [1:0][2:0]            w_in_lat;
    logic                       w_en_even;
    logic                       w_en_odd;

    assign w_in_valid = {res_valid_odd, res_valid_even};
    assign w_in_addr  = {res_addr_odd, res_addr_even};
    assign w_in_data  = {res_data_odd, res_data_even};
    assign w_in_lat   = {res_lat_odd, res_lat_even};

    // Next state: zeroing sweep in INIT; shift, then insert/reject results in RUN.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = r_done;
        w_err_next   = r_err;
        for (int p = 0; p < 2; p++) begin
            w_v_next[p] = r_v[p] >> 1;
            w_a_next[p] = r_a[p] >> ADDR_WIDTH;
            w_d_next[p] = r_d[p] >> REG_WIDTH;
        end
        unique case (r_state)
            StInit: begin
                w_v_next       = '0;
                w_a_next       = '0;
                w_d_next       = '0;
                w_v_next[0][0] = 1'b1;
                w_a_next[0][0] = r_cnt;
                w_v_next[1][0] = 1'b1;
                w_a_next[1][0] = r_cnt + ADDR_WIDTH'(HALF);
                w_cnt_next     = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == ADDR_WIDTH'(HALF - 1)) begin
                    w_state_next = StRun;
                    w_done_next  = 1'b1;
                    w_cnt_next   = '0;
                end
            end
            StRun: begin
                for (int p = 0; p < 2; p++) begin
                    if (w_in_valid[p]) begin
                        if (w_in_lat[p] == 3'd0 || int'(w_in_lat[p]) > PIPE_DEPTH) begin
                            w_err_next = 1'b1;
                        end else begin
                            for (int k = 0; k < PIPE_DEPTH; k++) begin
                                if (int'(w_in_lat[p]) == k + 1) begin
                                    // Target slot already holds an older result: keep it.
                                    if (w_v_next[p][k]) begin
                                        w_err_next = 1'b1;
                                    end else begin
                                        w_v_next[p][k] = 1'b1;
                                        w_a_next[p][k] = w_in_addr[p];
                                        w_d_next[p][k] = w_in_data[p];
                                    end
                                end
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StInit;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_v     <= '0;
            r_a     <= '0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_v     <= w_v_next;
            r_a     <= w_a_next;
            r_d     <= w_d_next;
        end
    end

    // Same-address heads: the odd write wins, the even one is suppressed.
    assign w_en_odd  = r_v[1][0];
    assign w_en_even = r_v[0][0] && !(r_v[1][0] && (r_a[1][0] == r_a[0][0]));

    assign wr_en_even      = w_en_even;
    assign wr_en_odd       = w_en_odd;
    assign addr_rt_wt_even = w_en_even ? r_a[0][0] : '0;
    assign addr_rt_wt_odd  = w_en_odd ? r_a[1][0] : '0;
    assign rt_wt_even      = w_en_even ? r_d[0][0] : '0;
    assign rt_wt_odd       = w_en_odd ? r_d[1][0] : '0;
    assign init_done       = r_done;
    assign wb_err          = r_err;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Scoreboard bench for rf_writeback_ctrl: expected writes are queued with their
// due cycle when stimulus is driven and compared every cycle on the falling edge.
module tb_rf_writeback_ctrl;

    localparam int AW  = 7;
    localparam int RW  = 128;
    localparam int BIG = 1 << 30;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          res_valid_even, res_valid_odd;
    logic [RW-1:0] res_data_even, res_data_odd;
    logic [AW-1:0] res_addr_even, res_addr_odd;
    logic [2:0]    res_lat_even, res_lat_odd;
    logic [RW-1:0] rt_wt_even, rt_wt_odd;
    logic [AW-1:0] addr_rt_wt_even, addr_rt_wt_odd;
    logic          wr_en_even, wr_en_odd;
    logic          init_done, wb_err;

    exp_t q_even[$];
    exp_t q_odd[$];
    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   done_from = BIG;
    int   err_from  = BIG;

    rf_writeback_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .res_valid_even  (res_valid_even),
        .res_valid_odd   (res_valid_odd),
        .res_data_even   (res_data_even),
        .res_data_odd    (res_data_odd),
        .res_addr_even   (res_addr_even),
        .res_addr_odd    (res_addr_odd),
        .res_lat_even    (res_lat_even),
        .res_lat_odd     (res_lat_odd),
        .rt_wt_even      (rt_wt_even),
        .rt_wt_odd       (rt_wt_odd),
        .addr_rt_wt_even (addr_rt_wt_even),
        .addr_rt_wt_odd  (addr_rt_wt_odd),
        .wr_en_even      (wr_en_even),
        .wr_en_odd       (wr_en_odd),
        .init_done       (init_done),
        .wb_err          (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic          en;
        logic [AW-1:0] a;
        logic [RW-1:0] d;
        en = 1'b0; a = '0; d = '0;
        if (q_even.size() > 0 && q_even[0].cyc == cyc) begin
            en = 1'b1; a = q_even[0].addr; d = q_even[0].data;
            void'(q_even.pop_front());
        end
        check_eq("wr_en_even", wr_en_even, en);
        check_eq("addr_even", addr_rt_wt_even, a);
        check_eq("data_even", rt_wt_even, d);
        en = 1'b0; a = '0; d = '0;
        if (q_odd.size() > 0 && q_odd[0].cyc == cyc) begin
            en = 1'b1; a = q_odd[0].addr; d = q_odd[0].data;
            void'(q_odd.pop_front());
        end
        check_eq("wr_en_odd", wr_en_odd, en);
        check_eq("addr_odd", addr_rt_wt_odd, a);
        check_eq("data_odd", rt_wt_odd, d);
        check_eq("init_done", init_done, cyc >= done_from);
        check_eq("wb_err", wb_err, cyc >= err_from);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic push(input int pipe, input int due, input logic [AW-1:0] a,
                        input logic [RW-1:0] d);
        exp_t e;
        e.cyc = due; e.addr = a; e.data = d;
        if (pipe == 0) q_even.push_back(e);
        else q_odd.push_back(e);
    endtask

    task automatic drive(input int pipe, input logic [AW-1:0] a, input logic [RW-1:0] d,
                         input logic [2:0] lat);
        if (pipe == 0) begin
            res_valid_even = 1'b1; res_addr_even = a; res_data_even = d; res_lat_even = lat;
        end else begin
            res_valid_odd = 1'b1; res_addr_odd = a; res_data_odd = d; res_lat_odd = lat;
        end
    endtask

    task automatic clear_inputs();
        res_valid_even = 1'b0; res_addr_even = '0; res_data_even = '0; res_lat_even = '0;
        res_valid_odd  = 1'b0; res_addr_odd  = '0; res_data_odd  = '0; res_lat_odd  = '0;
    endtask

    // Release reset and expect the first n zeroing writes (full sweep when n == 64).
    task automatic start_init(input int n);
        int c;
        c = cyc;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            push(0, c + 1 + i, AW'(i), '0);
            push(1, c + 1 + i, AW'(i + 64), '0);
        end
        if (n == 64) done_from = c + 64;
    endtask

    task automatic assert_reset();
        reset     = 1'b0;
        err_from  = BIG;
        done_from = BIG;
    endtask

    initial begin
        int            c;
        int            ce;
        logic [2:0]    le;
        logic [RW-1:0] de;
        logic [RW-1:0] dodd;

        clear_inputs();
        reset = 1'b0;
        repeat (3) tick();

        // Full zeroing sweep, then silence.
        start_init(64);
        repeat (68) tick();

        // Single even result, latency 3.
        c = cyc;
        drive(0, 7'd5, {16{8'hAA}}, 3'd3);
        push(0, c + 3, 7'd5, {16{8'hAA}});
        tick();
        clear_inputs();
        repeat (5) tick();

        // Same address on both pipes in the same cycle: odd wins, no error.
        c = cyc;
        drive(0, 7'd9, {8{16'h1111}}, 3'd2);
        drive(1, 7'd9, {8{16'h2222}}, 3'd2);
        push(1, c + 2, 7'd9, {8{16'h2222}});
        tick();
        clear_inputs();
        repeat (4) tick();

        // Odd result at the maximum latency.
        c = cyc;
        drive(1, 7'd12, {4{32'hC0FFEE01}}, 3'd7);
        push(1, c + 7, 7'd12, {4{32'hC0FFEE01}});
        tick();
        clear_inputs();
        repeat (9) tick();

        // Back-to-back results on both pipes with non-colliding latencies.
        for (int i = 0; i < 8; i++) begin
            ce   = cyc;
            le   = (i < 7) ? 3'(i + 1) : 3'd7;
            de   = {$urandom, $urandom, $urandom, $urandom};
            dodd = {$urandom, $urandom, $urandom, $urandom};
            drive(0, 7'(20 + i), de, le);
            push(0, ce + int'(le), 7'(20 + i), de);
            drive(1, 7'(40 + i), dodd, 3'd7);
            push(1, ce + 7, 7'(40 + i), dodd);
            tick();
        end
        clear_inputs();
        repeat (10) tick();

        // Latency 0 is dropped and flags an error.
        c = cyc;
        drive(1, 7'd13, {4{32'hDEADBEEF}}, 3'd0);
        err_from = c + 1;
        tick();
        clear_inputs();
        repeat (3) tick();

        // Queued RUN entries are discarded by reset.
        drive(0, 7'd3, {4{32'h33333333}}, 3'd7);
        drive(1, 7'd4, {4{32'h44444444}}, 3'd6);
        tick();
        clear_inputs();
        assert_reset();
        repeat (3) tick();

        // Zeroing interrupted by reset at counter 30; results in INIT are ignored.
        start_init(30);
        repeat (10) tick();
        drive(0, 7'd50, {4{32'h55555555}}, 3'd2);
        tick();
        clear_inputs();
        repeat (19) tick();
        assert_reset();
        repeat (2) tick();

        // Zeroing restarts from address 0/64.
        start_init(64);
        repeat (66) tick();

        // Collision: lat 4 then lat 3 on the next cycle; only the first survives.
        c = cyc;
        drive(0, 7'd10, {4{32'h0A0A0A0A}}, 3'd4);
        push(0, c + 4, 7'd10, {4{32'h0A0A0A0A}});
        tick();
        drive(0, 7'd11, {4{32'h0B0B0B0B}}, 3'd3);
        err_from = c + 2;
        tick();
        clear_inputs();
        repeat (6) tick();

        check_eq("q_even_drained", RW'(q_even.size()), '0);
        check_eq("q_odd_drained", RW'(q_odd.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_writeback_ctrl.md
RF_WRITEBACK_CTRL -- requirements
Module: rf_writeback_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 128, meaning register width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 128, meaning register count; ADDR_WIDTH = clog2(REG_COUNT), local.
REQ-003 SHALL have parameter PIPE_DEPTH, default 7, meaning maximum result-to-writeback latency in cycles.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- res_valid_even / res_valid_odd  in  1  execution result presented by the even / odd pipe.
- res_data_even / res_data_odd  in  REG_WIDTH  result value.
- res_addr_even / res_addr_odd  in  ADDR_WIDTH  destination register.
- res_lat_even / res_lat_odd  in  3  cycles until writeback, legal 1..PIPE_DEPTH.
- rt_wt_even / rt_wt_odd  out  REG_WIDTH  register-file write data.
- addr_rt_wt_even / addr_rt_wt_odd  out  ADDR_WIDTH  register-file write address.
- wr_en_even / wr_en_odd  out  1  register-file write enable.
- init_done  out  1  high once register-file zeroing is complete.
- wb_err  out  1  sticky error flag.

Function
REQ-005 SHALL implement a two-state FSM: INIT, RUN.
REQ-006 INIT SHALL use an init counter starting at 0; each cycle it SHALL drive wr_en_even=1 with address=counter, wr_en_odd=1 with address=counter+REG_COUNT/2, and both data=0.
REQ-007 INIT SHALL increment the counter each cycle and, after the write with counter=REG_COUNT/2-1, SHALL transition to RUN, setting init_done=1 in the same edge.
REQ-008 In INIT, all res_valid inputs SHALL be ignored; no entries SHALL be queued.
REQ-009 In RUN, each pipe SHALL own an independent delay line of PIPE_DEPTH slots, each holding valid, addr, and data.
REQ-010 A result with res_valid=1 and lat=d accepted at edge t SHALL produce the corresponding wr_en=1 with its addr/data during the cycle following edge t+d-1, i.e. it is visible d cycles after presentation.
REQ-011 The delay lines SHALL shift one slot toward writeback every cycle; the head slot SHALL drive the write outputs registered.
REQ-012 If the target slot of a new result is already valid (collision), the new result SHALL be dropped, the existing entry kept, and wb_err set.
REQ-013 If lat=0 or lat>PIPE_DEPTH, the result SHALL be dropped and wb_err set.
REQ-014 If both pipes write the same address in the same cycle, the odd write SHALL proceed and wr_en_even SHALL be forced to 0 for that cycle; this is not an error.
REQ-015 When no head entry is valid, wr_en SHALL be 0; addr and data outputs are don't-care but SHALL be driven 0.
REQ-016 The even and odd pipes SHALL be fully independent except as stated in REQ-014.

Reset
REQ-017 While reset=0 at a rising edge: FSM to INIT, init counter to 0, all delay-line valids cleared, init_done=0, wb_err=0, and all outputs 0 after that edge.
REQ-018 Reset asserted mid-INIT or mid-RUN SHALL discard all queued results and restart zeroing from address 0 on the first edge with reset=1.
REQ-019 wb_err SHALL clear only on reset.

Verification
REQ-020 Release reset -> 64 cycles of dual writes (even 0..63, odd 64..127, data 0), init_done rises after write 63/127, and no further writes occur.
REQ-021 In RUN, even result addr=5, data=0xAA.., lat=3 at cycle t -> wr_en_even=1, addr 5, data 0xAA.. exactly at cycle t+3, with no other even writes.
REQ-022 Even lat=4 at t, then lat=3 at t+1 -> collision; first write at t+4 only, and wb_err=1.
REQ-023 Even and odd both addr=9, lat=2, same cycle -> at t+2 only wr_en_odd=1 (addr 9), wr_en_even=0, and wb_err stays 0.
REQ-024 Odd lat=0, and separately lat=7 -> first is dropped with wb_err=1; second writes at t+7.
REQ-025 Reset asserted at init counter 30 with queued RUN entries -> no queued writes appear, and zeroing restarts at addresses 0/64.
